// File: rtl/transposer_job_sched_pkg.sv
// transposer_pkg: shared widths, job descriptor and scheduler state encoding.
package transposer_pkg;
    localparam int AW = 16;
    localparam int ADIM = 6;
    typedef struct packed {
        logic                     repack_en;
        logic [1:0]               mode;
        logic [AW-1:0]            rreq_num;
        logic [AW-1:0]            raddr_base;
        logic [ADIM-1:0][AW-1:0]  raddr_size;
        logic [ADIM-1:0][AW-1:0]  raddr_stride;
        logic [AW-1:0]            wreq_num;
        logic [AW-1:0]            waddr_base;
        logic [ADIM-1:0][AW-1:0]  waddr_size;
        logic [ADIM-1:0][AW-1:0]  waddr_stride;
        logic [AW-1:0]            packed_dim_size;
        logic [AW-1:0]            unpacked_dim_size;
    } xpose_desc_t;
    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} sched_state_e;
endpackage

// File: rtl/transposer_job_sched_if.sv
// transposer_job_sched_if: requester handshake plus transposer config/control bus.
interface transposer_job_sched_if
    import transposer_pkg::*;
#(parameter int NREQ = 4);
    logic [NREQ-1:0]          req_vld, req_rdy, job_done, job_err;
    xpose_desc_t              req_desc [NREQ];
    logic                     busy, init_pulse, finish;
    logic                     repack_en;
    logic [1:0]               mode;
    logic [AW-1:0]            rreq_num, raddr_base, wreq_num, waddr_base;
    logic [AW-1:0]            packed_dim_size, unpacked_dim_size;
    logic [ADIM-1:0][AW-1:0]  raddr_size, raddr_stride, waddr_size, waddr_stride;
    modport master (
        input  req_vld, req_desc, finish,
        output req_rdy, job_done, job_err, busy, init_pulse,
               repack_en, mode, rreq_num, raddr_base, raddr_size, raddr_stride,
               wreq_num, waddr_base, waddr_size, waddr_stride, packed_dim_size, unpacked_dim_size
    );
    modport slave (
        output req_vld, req_desc, finish,
        input  req_rdy, job_done, job_err, busy, init_pulse,
               repack_en, mode, rreq_num, raddr_base, raddr_size, raddr_stride,
               wreq_num, waddr_base, waddr_size, waddr_stride, packed_dim_size, unpacked_dim_size
    );
endinterface

// File: rtl/transposer_job_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, lowest index at or after ptr wins.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] id
);
    logic [IW-1:0] j;
    always_comb begin
        gnt = '0;
        id = '0;
        j = '0;
        // scan farthest-first so the nearest requester after ptr overwrites
        for (int i = N - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % N);
            if (req[j]) begin
                gnt = N'(1) << j;
                id = j;
            end
        end
    end
endmodule

// File: rtl/transposer_job_sched.sv
// transposer_job_sched: round-robin job scheduler sharing one transposer among NREQ requesters.
// Optional TRANSPOSER_TIMEOUT_EN adds a RUN watchdog that ends a job with job_err.
module transposer_job_sched
    import transposer_pkg::*;
#(
    parameter int NREQ = 4
`ifdef TRANSPOSER_TIMEOUT_EN
    , parameter int TOW = 20
`endif
) (
    input logic clk,
    input logic reset,
    transposer_job_sched_if.master bus
);
    localparam int IW = $clog2(NREQ);
    sched_state_e  state_q, state_d;
    logic [IW-1:0] ptr_q, owner_q, win_id;
    logic [NREQ-1:0] win_gnt;
    xpose_desc_t   cfg_q;
    logic          timeout, err_q;

    rr_arbiter #(.N(NREQ)) u_arb (.req(bus.req_vld), .ptr(ptr_q), .gnt(win_gnt), .id(win_id));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = |bus.req_vld ? LOAD : IDLE;
            LOAD:    state_d = START;
            START:   state_d = RUN;
            RUN:     state_d = (bus.finish || timeout) ? DONE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // config is captured at the grant edge so it is already valid during LOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q <= '0;
            owner_q <= '0;
            cfg_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |bus.req_vld) begin
                owner_q <= win_id;
                cfg_q <= bus.req_desc[win_id];
            end
            if (state_q == DONE)
                ptr_q <= owner_q == IW'(NREQ - 1) ? '0 : owner_q + IW'(1);
        end
    end

`ifdef TRANSPOSER_TIMEOUT_EN
    // the transposer is not reset here on timeout; the integrator must reset it
    logic [TOW-1:0] cnt_q;
    assign timeout = state_q == RUN && &cnt_q && !bus.finish;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= state_q == START ? '0 : state_q == RUN ? cnt_q + TOW'(1) : cnt_q;
            err_q <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_q = 1'b0;
`endif

    assign bus.req_rdy = state_q == IDLE ? win_gnt : '0;
    assign bus.init_pulse = state_q == START;
    assign bus.busy = state_q != IDLE;
    assign bus.job_done = (state_q == DONE && !err_q) ? NREQ'(1) << owner_q : '0;
    assign bus.job_err = (state_q == DONE && err_q) ? NREQ'(1) << owner_q : '0;
    assign {bus.repack_en, bus.mode, bus.rreq_num, bus.raddr_base, bus.raddr_size, bus.raddr_stride,
            bus.wreq_num, bus.waddr_base, bus.waddr_size, bus.waddr_stride,
            bus.packed_dim_size, bus.unpacked_dim_size} = cfg_q;
endmodule

// File: tb/tb_transposer_job_sched.sv
// tb_transposer_job_sched: directed scoreboard bench for the transposer job scheduler.
module tb_transposer_job_sched;
    import transposer_pkg::*;
    localparam int NREQ = 4;

    typedef struct {
        int          id;
        xpose_desc_t d;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    transposer_job_sched_if #(.NREQ(NREQ)) bus ();

    transposer_job_sched #(
        .NREQ(NREQ)
`ifdef TRANSPOSER_TIMEOUT_EN
        , .TOW(4)
`endif
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t sb[$];
    int   gq[$];
    int   checks = 0;
    int   errors = 0;
    int   ptr_m = 0;
    int   lat;
    int   exp_order[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic xpose_desc_t get_cfg();
        return {bus.repack_en, bus.mode, bus.rreq_num, bus.raddr_base, bus.raddr_size, bus.raddr_stride,
                bus.wreq_num, bus.waddr_base, bus.waddr_size, bus.waddr_stride,
                bus.packed_dim_size, bus.unpacked_dim_size};
    endfunction

    function automatic xpose_desc_t rnd_desc();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return xpose_desc_t'(r[$bits(xpose_desc_t)-1:0]);
    endfunction

    task automatic set_descs();
        for (int i = 0; i < NREQ; i++) bus.req_desc[i] = rnd_desc();
    endtask

    function automatic int rr_win(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic int oh_id(logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++)
            if (v == NREQ'(1) << i) return i;
        return -1;
    endfunction

    // Called at the negedge of an IDLE cycle; returns at the negedge of the IDLE cycle after DONE.
    task automatic do_job(input logic [NREQ-1:0] vld, input bit keep, input int fin_wait,
                          input bit stale, input logic [NREQ-1:0] side);
        exp_t e;
        bus.req_vld = vld;
        #1;
        e.id = rr_win(vld, ptr_m);
        e.d = bus.req_desc[e.id];
        chk("grant", bus.req_rdy, NREQ'(1) << e.id);
        sb.push_back(e);
        gq.push_back(oh_id(bus.req_rdy));
        @(negedge clk);
        if (!keep) bus.req_vld = '0;
        bus.finish = stale;
        #1;
        chk("load_busy", bus.busy, 1);
        chk("load_init", bus.init_pulse, 0);
        chk("load_rdy", bus.req_rdy, 0);
        chk("load_cfg", get_cfg(), sb[0].d);
        @(negedge clk);
        bus.finish = stale;
        #1;
        chk("start_init", bus.init_pulse, 1);
        chk("start_cfg", get_cfg(), sb[0].d);
        for (int c = 1; c < fin_wait; c++) begin
            @(negedge clk);
            bus.finish = 1'b0;
            bus.req_vld = side | (keep ? vld : '0);
            #1;
            chk("run_init", bus.init_pulse, 0);
            chk("run_done", bus.job_done, 0);
            chk("run_rdy", bus.req_rdy, 0);
            chk("run_busy", bus.busy, 1);
        end
        @(negedge clk);
        bus.finish = 1'b1;
        bus.req_vld = keep ? vld : '0;
        #1;
        chk("fin_done", bus.job_done, 0);
        @(negedge clk);
        bus.finish = 1'b0;
        #1;
        e = sb.pop_front();
        chk("done", bus.job_done, NREQ'(1) << e.id);
        chk("done_err", bus.job_err, 0);
        chk("done_busy", bus.busy, 1);
        ptr_m = (e.id + 1) % NREQ;
        @(negedge clk);
        #1;
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.job_done, 0);
        chk("hold_cfg", get_cfg(), e.d);
        if (!keep) chk("idle_rdy", bus.req_rdy, 0);
    endtask

    initial begin
        bus.req_vld = '0;
        bus.finish = 1'b0;
        set_descs();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdy", bus.req_rdy, 0);
        chk("rst_done", bus.job_done, 0);
        chk("rst_err", bus.job_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_init", bus.init_pulse, 0);
        chk("rst_cfg", get_cfg(), 0);
        reset = 1'b0;
        @(negedge clk);

        // single job on requester 2, long run
        do_job(4'b0100, 1'b0, 28, 1'b0, 4'b0000);

        // config timing with a known descriptor; pointer at 3 picks 3 over 0
        set_descs();
        bus.req_desc[3].rreq_num = 16'h0123;
        bus.req_desc[3].mode = 2'd2;
        do_job(4'b1001, 1'b0, 3, 1'b0, 4'b0000);
        chk("cfg_rreq", bus.rreq_num, 16'h0123);
        chk("cfg_mode", bus.mode, 2'd2);

        // finish during LOAD and START must be ignored
        set_descs();
        do_job(4'b0010, 1'b0, 4, 1'b1, 4'b0000);

        // requester 3 raises and retracts vld while busy; no grant results
        set_descs();
        do_job(4'b0001, 1'b0, 4, 1'b0, 4'b1000);

        // fairness from a fresh pointer with all requesters held
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
        gq.delete();
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            set_descs();
            do_job(4'b1111, k < 4, 5, 1'b0, 4'b0000);
        end
        bus.req_vld = '0;
        chk("order_len", gq.size(), 5);
        for (int k = 0; k < 5; k++) chk("order", gq[k], exp_order[k]);
        @(negedge clk);

        // reset mid-RUN, with finish in the reset cycle
        set_descs();
        bus.req_vld = 4'b0100;
        #1;
        chk("mr_grant", bus.req_rdy, 4'b0100);
        @(negedge clk);
        bus.req_vld = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.finish = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.finish = 1'b0;
        #1;
        chk("mr_rdy", bus.req_rdy, 0);
        chk("mr_done", bus.job_done, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_init", bus.init_pulse, 0);
        chk("mr_cfg", get_cfg(), 0);
        @(negedge clk);
        #1;
        chk("mr_done2", bus.job_done, 0);
        ptr_m = 0;
        set_descs();
        do_job(4'b0011, 1'b0, 2, 1'b0, 4'b0000);
        set_descs();
        do_job(4'b0010, 1'b0, 2, 1'b0, 4'b0000);

        // no finish at all: watchdog or indefinite wait
        set_descs();
        bus.req_vld = 4'b0001;
        #1;
        chk("to_grant", bus.req_rdy, 4'b0001);
        @(negedge clk);
        bus.req_vld = '0;
        @(negedge clk);
        #1;
        chk("to_start", bus.init_pulse, 1);
`ifdef TRANSPOSER_TIMEOUT_EN
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            #1;
            if (bus.job_err != '0) begin
                lat = k;
                break;
            end
            chk("to_nodone", bus.job_done, 0);
        end
        chk("to_latency", lat, 17);
        chk("to_err", bus.job_err, 4'b0001);
        chk("to_done", bus.job_done, 0);
        @(negedge clk);
        #1;
        chk("to_idle", bus.busy, 0);
`else
        repeat (40) @(negedge clk);
        #1;
        chk("hang_busy", bus.busy, 1);
        chk("hang_done", bus.job_done, 0);
        chk("hang_err", bus.job_err, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("hang_rst", bus.busy, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
